// File: rtl/sd_cmd_arbiter.sv
// Purpose : shares the SD CMD engine between software and DMA requesters (round-robin or DMA priority).
// Latency : req -> new_command 2 edges; cmd_complete -> done pulse 2 edges; timeout after TIMEOUT_CYCLES in WAIT.
// Backpress: one command in flight; requests arriving while busy stay pending (req level) until granted.
//
// Ports (all synchronous to i_clk_host, reset i_reset_host synchronous active-high):
//   i_sw_req/i_sw_index/i_sw_arg, o_sw_ack/o_sw_done       software requester
//   i_dma_req/i_dma_index/i_dma_arg, o_dma_ack/o_dma_done  DMA requester
//   o_new_command/o_cmd_index/o_cmd_argument               start pulse + latched command to CMD block
//   i_cmd_complete/i_cmd_index_error/i_response            completion from CMD block (first cycle used)
//   o_resp_out, o_err_index, o_err_timeout                 result of the last command
//   o_owner (0 = software, 1 = DMA), o_busy                current ownership
// Build option: define SD_CMD_ARB_DMA_PRIO_EN for fixed DMA priority instead of round-robin.
module sd_cmd_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 16
) (
    input  logic         i_clk_host,
    input  logic         i_reset_host,
    input  logic         i_sw_req,
    input  logic [5:0]   i_sw_index,
    input  logic [31:0]  i_sw_arg,
    output logic         o_sw_ack,
    output logic         o_sw_done,
    input  logic         i_dma_req,
    input  logic [5:0]   i_dma_index,
    input  logic [31:0]  i_dma_arg,
    output logic         o_dma_ack,
    output logic         o_dma_done,
    output logic         o_new_command,
    output logic [5:0]   o_cmd_index,
    output logic [31:0]  o_cmd_argument,
    input  logic         i_cmd_complete,
    input  logic         i_cmd_index_error,
    input  logic [127:0] i_response,
    output logic [127:0] o_resp_out,
    output logic         o_err_index,
    output logic         o_err_timeout,
    output logic         o_owner,
    output logic         o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [TO_W-1:0] r_count;

    logic           r_sw_ack, r_sw_done, r_dma_ack, r_dma_done;
    logic           r_new_command, r_err_index, r_err_timeout, r_owner, r_busy;
    logic [5:0]     r_cmd_index;
    logic [31:0]    r_cmd_argument;
    logic [127:0]   r_resp_out;

    logic           w_pick_dma;
    logic           w_grant, w_issue, w_capture, w_timeout, w_finish, w_count_dec;
    logic           w_count_zero;

    assign w_count_zero = (r_count == '0);

`ifdef SD_CMD_ARB_DMA_PRIO_EN
    // DMA wins every tie; no history needed.
    assign w_pick_dma = i_dma_req;
`else
    // 1 = DMA was granted last. Reset to DMA so software wins the first tie.
    logic r_last_grant;

    always_ff @(posedge i_clk_host) begin
        if (i_reset_host) begin
            r_last_grant <= 1'b1;
        end else if (w_grant) begin
            r_last_grant <= w_pick_dma;
        end
    end

    assign w_pick_dma = i_dma_req & (~i_sw_req | ~r_last_grant);
`endif

    always_ff @(posedge i_clk_host) begin
        if (i_reset_host) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        w_finish    = 1'b0;
        w_count_dec = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_sw_req || i_dma_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_issue     = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Completion takes precedence over an expiring counter.
                if (i_cmd_complete) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_count_zero) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_count_dec = 1'b1;
                end
            end
            S_DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_host) begin
        if (i_reset_host) begin
            r_sw_ack       <= 1'b0;
            r_sw_done      <= 1'b0;
            r_dma_ack      <= 1'b0;
            r_dma_done     <= 1'b0;
            r_new_command  <= 1'b0;
            r_cmd_index    <= '0;
            r_cmd_argument <= '0;
            r_resp_out     <= '0;
            r_err_index    <= 1'b0;
            r_err_timeout  <= 1'b0;
            r_owner        <= 1'b0;
            r_busy         <= 1'b0;
            r_count        <= '0;
        end else begin
            // Pulse outputs default low every cycle.
            r_sw_ack      <= 1'b0;
            r_dma_ack     <= 1'b0;
            r_sw_done     <= 1'b0;
            r_dma_done    <= 1'b0;
            r_new_command <= 1'b0;

            if (w_grant) begin
                r_owner        <= w_pick_dma;
                r_busy         <= 1'b1;
                r_sw_ack       <= ~w_pick_dma;
                r_dma_ack      <= w_pick_dma;
                r_cmd_index    <= w_pick_dma ? i_dma_index : i_sw_index;
                r_cmd_argument <= w_pick_dma ? i_dma_arg : i_sw_arg;
            end

            if (w_issue) begin
                r_new_command <= 1'b1;
                r_err_index   <= 1'b0;
                r_err_timeout <= 1'b0;
                r_count       <= TO_W'(TIMEOUT_CYCLES - 1);
            end else if (w_count_dec) begin
                r_count <= r_count - TO_W'(1);
            end

            if (w_capture) begin
                r_resp_out  <= i_response;
                r_err_index <= i_cmd_index_error;
            end

            if (w_timeout) begin
                r_err_timeout <= 1'b1;
            end

            if (w_finish) begin
                r_sw_done  <= ~r_owner;
                r_dma_done <= r_owner;
                r_busy     <= 1'b0;
            end
        end
    end

    assign o_sw_ack       = r_sw_ack;
    assign o_sw_done      = r_sw_done;
    assign o_dma_ack      = r_dma_ack;
    assign o_dma_done     = r_dma_done;
    assign o_new_command  = r_new_command;
    assign o_cmd_index    = r_cmd_index;
    assign o_cmd_argument = r_cmd_argument;
    assign o_resp_out     = r_resp_out;
    assign o_err_index    = r_err_index;
    assign o_err_timeout  = r_err_timeout;
    assign o_owner        = r_owner;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Purpose : self-checking bench for sd_cmd_arbiter with a short timeout.
// Latency : expectations derived from the edge-by-edge command timeline.
// Backpress: requesters hold req until ack, then drop it the following cycle.
module tb_sd_cmd_arbiter;

    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         reset_host;
    logic         sw_req, dma_req;
    logic [5:0]   sw_index, dma_index;
    logic [31:0]  sw_arg, dma_arg;
    logic         sw_ack, sw_done, dma_ack, dma_done;
    logic         new_command;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_argument;
    logic         cmd_complete, cmd_index_error;
    logic [127:0] response, resp_out;
    logic         err_index, err_timeout, owner, busy;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: who was granted last (1 = DMA) and the last captured response.
    bit           last_dma = 1'b1;
    logic [127:0] exp_resp = '0;

    always #5 clk = ~clk;

    sd_cmd_arbiter #(.TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
        .i_clk_host        (clk),
        .i_reset_host      (reset_host),
        .i_sw_req          (sw_req),
        .i_sw_index        (sw_index),
        .i_sw_arg          (sw_arg),
        .o_sw_ack          (sw_ack),
        .o_sw_done         (sw_done),
        .i_dma_req         (dma_req),
        .i_dma_index       (dma_index),
        .i_dma_arg         (dma_arg),
        .o_dma_ack         (dma_ack),
        .o_dma_done        (dma_done),
        .o_new_command     (new_command),
        .o_cmd_index       (cmd_index),
        .o_cmd_argument    (cmd_argument),
        .i_cmd_complete    (cmd_complete),
        .i_cmd_index_error (cmd_index_error),
        .i_response        (response),
        .o_resp_out        (resp_out),
        .o_err_index       (err_index),
        .o_err_timeout     (err_timeout),
        .o_owner           (owner),
        .o_busy            (busy)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arbitration rule: a lone request wins; on a tie the requester not granted last wins
    // (or DMA always wins in the priority build).
    function automatic bit pick_dma(input bit s, input bit d);
`ifdef SD_CMD_ARB_DMA_PRIO_EN
        return d;
`else
        if (s && d) return !last_dma;
        return d;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_sw_ack"},   sw_ack, 0);
        check({tag, "_dma_ack"},  dma_ack, 0);
        check({tag, "_sw_done"},  sw_done, 0);
        check({tag, "_dma_done"}, dma_done, 0);
        check({tag, "_newcmd"},   new_command, 0);
        check({tag, "_cmdidx"},   cmd_index, 0);
        check({tag, "_cmdarg"},   cmd_argument, 0);
        check({tag, "_resp"},     resp_out, 0);
        check({tag, "_erridx"},   err_index, 0);
        check({tag, "_errto"},    err_timeout, 0);
        check({tag, "_owner"},    owner, 0);
        check({tag, "_busy"},     busy, 0);
    endtask

    // One full command. Requests must already be driven. d = edges after new_command at
    // which cmd_complete is sampled (1..TO); d = 0 means no completion (timeout).
    task automatic txn(input int d, input bit ierr, input logic [127:0] resp);
        bit          g;
        logic [5:0]  ei;
        logic [31:0] ea;
        g  = pick_dma(sw_req, dma_req);
        ei = g ? dma_index : sw_index;
        ea = g ? dma_arg : sw_arg;
        last_dma = g;

        tick();  // grant edge
        check("ack_sw",    sw_ack, !g);
        check("ack_dma",   dma_ack, g);
        check("grant_busy", busy, 1);
        check("grant_owner", owner, g);
        check("grant_nodone", sw_done | dma_done, 0);
        if (g) dma_req = 1'b0; else sw_req = 1'b0;

        tick();  // issue edge
        check("newcmd",    new_command, 1);
        check("cmd_index", cmd_index, ei);
        check("cmd_arg",   cmd_argument, ea);
        check("ack_gone",  sw_ack | dma_ack, 0);
        check("issue_eidx", err_index, 0);
        check("issue_eto",  err_timeout, 0);

        if (d == 0) begin
            repeat (TO - 1) tick();
            check("to_early", err_timeout, 0);
            check("newcmd_once", new_command, 0);
            tick();  // TIMEOUT_CYCLES edges after issue
            check("to_set",   err_timeout, 1);
            check("to_busy",  busy, 1);
            check("to_nodone", sw_done | dma_done, 0);
        end else begin
            repeat (d - 1) tick();
            cmd_complete    = 1'b1;
            cmd_index_error = ierr;
            response        = resp;
            tick();  // completion sampled
            cmd_complete    = 1'b0;
            cmd_index_error = 1'($urandom_range(0, 1));
            response        = {$urandom, $urandom, $urandom, $urandom};
            exp_resp        = resp;
            check("cpl_busy",   busy, 1);
            check("cpl_nodone", sw_done | dma_done, 0);
            check("cpl_resp",   resp_out, exp_resp);
            check("cpl_eidx",   err_index, ierr);
            check("cpl_eto",    err_timeout, 0);
        end

        tick();  // leave DONE
        check("done_sw",    sw_done, !g);
        check("done_dma",   dma_done, g);
        check("done_busy",  busy, 0);
        check("done_owner", owner, g);
        check("done_resp",  resp_out, exp_resp);
        check("done_eto",   err_timeout, d == 0);
    endtask

    initial begin
        reset_host      = 1'b1;
        sw_req          = 1'b0;
        dma_req         = 1'b0;
        sw_index        = '0;
        dma_index       = '0;
        sw_arg          = '0;
        dma_arg         = '0;
        cmd_complete    = 1'b0;
        cmd_index_error = 1'b0;
        response        = '0;
        tick();
        tick();
        check_all_zero("rst");
        reset_host = 1'b0;

        // Software command, completion 5 edges after new_command.
        sw_req = 1'b1; sw_index = 6'd17; sw_arg = 32'h0000_0200;
        txn(5, 1'b0, 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978);

        // Both requesters on the same edge: tie broken by the arbitration rule, loser stays pending.
        sw_req = 1'b1;  sw_index = 6'd8;  sw_arg = 32'hAAAA_0001;
        dma_req = 1'b1; dma_index = 6'd18; dma_arg = 32'h5555_0002;
        txn(2, 1'b0, 128'h11);
        txn(3, 1'b0, 128'h22);

        // No completion: timeout.
        sw_req = 1'b1; sw_index = 6'd55; sw_arg = 32'hDEAD_BEEF;
        txn(0, 1'b0, '0);

        // Index error with patterned response.
        dma_req = 1'b1; dma_index = 6'd6; dma_arg = 32'h0000_0001;
        txn(4, 1'b1, {16{8'hA5}});

        // Completion on the same edge the counter expires: completion wins.
        sw_req = 1'b1; sw_index = 6'd13; sw_arg = 32'h0001_0000;
        txn(TO, 1'b0, 128'hCAFE_F00D);

        // cmd_complete while idle is ignored.
        cmd_complete = 1'b1; response = '1; cmd_index_error = 1'b1;
        tick();
        cmd_complete = 1'b0;
        tick();
        check("idle_cpl_busy", busy, 0);
        check("idle_cpl_resp", resp_out, exp_resp);
        check("idle_cpl_done", sw_done | dma_done, 0);

        // Reset in the middle of WAIT.
        sw_req = 1'b1; sw_index = 6'd3; sw_arg = 32'h77;
        tick();
        check("rw_ack", sw_ack, 1);
        sw_req = 1'b0;
        tick();
        tick();
        tick();
        reset_host = 1'b1;
        tick();
        reset_host = 1'b0;
        check_all_zero("midrst");
        tick();
        check("midrst_nodone", sw_done | dma_done, 0);
        check("midrst_idle",   busy, 0);
        last_dma = 1'b1;
        exp_resp = '0;

        // Randomized traffic with pending requests carried over between commands.
        for (int it = 0; it < 30; it++) begin
            int d;
            if (!sw_req && $urandom_range(0, 1) == 1) begin
                sw_req = 1'b1; sw_index = 6'($urandom); sw_arg = $urandom;
            end
            if (!dma_req && $urandom_range(0, 1) == 1) begin
                dma_req = 1'b1; dma_index = 6'($urandom); dma_arg = $urandom;
            end
            if (!sw_req && !dma_req) begin
                sw_req = 1'b1; sw_index = 6'($urandom); sw_arg = $urandom;
            end
            d = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TO));
            txn(d, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom});
        end
        for (int k = 0; k < 2 && (sw_req || dma_req); k++) begin
            txn(1, 1'b0, {$urandom, $urandom, $urandom, $urandom});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
